// File: rtl/pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_fade_ctrl
// Description : Bus-mapped duty-cycle fader. It steps the PWM duty register by
//               one unit per programmable interval until the written target is
//               reached.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_fade_ctrl #(
  parameter int PRESCALE = 50_000,
  parameter int DUTY_MAX = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic [6:0]  duty_wd,
  output logic        duty_we,
  output logic        busy,
  output logic        done
);

  localparam int               c_PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);
  localparam logic [6:0]       c_DUTY_MAX = 7'(DUTY_MAX);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t             r_state,   w_state;
  logic [6:0]         r_current, w_current;
  logic [6:0]         r_target,  w_target;
  logic [15:0]        r_interval, w_interval;
  logic [c_PS_W-1:0]  r_prescale_cnt, w_prescale_cnt;
  logic [15:0]        r_tick_cnt, w_tick_cnt;
  logic [6:0]         r_duty_wd, w_duty_wd;
  logic               r_duty_we, w_duty_we;
  logic               r_done,    w_done;

  logic [6:0]         w_sat;
  logic [6:0]         w_next_cur;
  logic               w_tick;
  logic               w_step_due;
  logic               w_unused;

  assign w_unused = &{1'b0, WD[31:16]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_current      <= '0;
      r_target       <= '0;
      r_interval     <= '0;
      r_prescale_cnt <= '0;
      r_tick_cnt     <= '0;
      r_duty_wd      <= '0;
      r_duty_we      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_current      <= w_current;
      r_target       <= w_target;
      r_interval     <= w_interval;
      r_prescale_cnt <= w_prescale_cnt;
      r_tick_cnt     <= w_tick_cnt;
      r_duty_wd      <= w_duty_wd;
      r_duty_we      <= w_duty_we;
      r_done         <= w_done;
    end
  end

  always_comb begin
    w_state        = r_state;
    w_current      = r_current;
    w_target       = r_target;
    w_interval     = r_interval;
    w_prescale_cnt = r_prescale_cnt;
    w_tick_cnt     = r_tick_cnt;
    w_duty_wd      = r_duty_wd;
    w_duty_we      = 1'b0;
    w_done         = 1'b0;
    w_next_cur     = r_current;

    w_sat      = (WD[6:0] > c_DUTY_MAX) ? c_DUTY_MAX : WD[6:0];
    w_tick     = (r_prescale_cnt == c_PS_LAST);
    // ">=" lets a shortened interval fire on the very next tick
    w_step_due = (r_interval == 16'd0) ||
                 (w_tick && (({1'b0, r_tick_cnt} + 17'd1) >= {1'b0, r_interval}));

    if (r_state == ST_RAMP) begin
      if (w_tick) begin
        w_prescale_cnt = '0;
        w_tick_cnt     = w_step_due ? 16'd0 : r_tick_cnt + 16'd1;
      end else begin
        w_prescale_cnt = r_prescale_cnt + c_PS_W'(1);
      end

      // Any bus write on this edge takes priority and the step is dropped
      if (w_step_due && !WE) begin
        if (r_interval == 16'd0)
          w_next_cur = r_target;
        else if (r_target > r_current)
          w_next_cur = r_current + 7'd1;
        else
          w_next_cur = r_current - 7'd1;
        w_current = w_next_cur;
        w_duty_wd = w_next_cur;
        w_duty_we = 1'b1;
        if (w_next_cur == r_target) begin
          w_state        = ST_IDLE;
          w_done         = 1'b1;
          w_prescale_cnt = '0;
          w_tick_cnt     = '0;
        end
      end
    end

    if (WE) begin
      case (A)
        2'd0: begin
          w_target       = w_sat;
          w_prescale_cnt = '0;
          w_tick_cnt     = '0;
          if (w_sat != r_current) begin
            w_state = ST_RAMP;
          end else begin
            w_state = ST_IDLE;
            w_done  = 1'b1;
          end
        end
        2'd1: w_interval = WD[15:0];
        2'd2: begin
          if (WD[0] && (r_state == ST_RAMP)) begin
            w_state        = ST_IDLE;
            w_prescale_cnt = '0;
            w_tick_cnt     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    RD = 32'd0;
    case (A)
      2'd0:    RD = {25'd0, r_target};
      2'd1:    RD = {16'd0, r_interval};
      2'd2:    RD = {16'd0, 1'b0, r_current, 7'd0, (r_state == ST_RAMP)};
      default: RD = 32'd0;
    endcase
  end

  assign duty_wd = r_duty_wd;
  assign duty_we = r_duty_we;
  assign busy    = (r_state == ST_RAMP);
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_fade_ctrl
// Description : Self-checking bench for pwm_fade_ctrl with an elapsed-cycle
//               reference model, directed scenarios and random bus traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_fade_ctrl;

  localparam int P    = 4;
  localparam int DMAX = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic [6:0]  duty_wd;
  logic        duty_we;
  logic        busy;
  logic        done;

  pwm_fade_ctrl #(.PRESCALE(P), .DUTY_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .RD(RD),
    .duty_wd(duty_wd), .duty_we(duty_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cyc   = 0;

  // Reference model: m_since = clock edges since the ramp (re)started or last stepped
  int m_cur = 0, m_tgt = 0, m_int = 0, m_since = 0, m_duty = 0;
  bit m_ramp = 0, m_we = 0, m_done = 0;

  typedef struct { int c; int val; bit dn; } ev_t;
  ev_t evq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_tgt);
      2'd1:    return 32'(m_int);
      2'd2:    return 32'((m_cur << 8) | int'(m_ramp));
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = 0; m_tgt = 0; m_int = 0; m_since = 0; m_duty = 0;
      m_ramp = 0; m_we = 0; m_done = 0;
    end else begin
      bit tick_now, due;
      int sat;
      m_we = 0;
      m_done = 0;
      if (m_ramp) begin
        tick_now = ((m_since + 1) % P) == 0;
        due = (m_int == 0) || (tick_now && ((m_since + 1) / P >= m_int));
        m_since = (tick_now && due) ? 0 : m_since + 1;
        if (due && !WE) begin
          if (m_int == 0) m_cur = m_tgt;
          else m_cur = (m_tgt > m_cur) ? m_cur + 1 : m_cur - 1;
          m_duty = m_cur;
          m_we = 1;
          if (m_cur == m_tgt) begin
            m_ramp = 0; m_done = 1; m_since = 0;
          end
        end
      end
      if (WE) begin
        case (A)
          2'd0: begin
            sat = (int'(WD[6:0]) > DMAX) ? DMAX : int'(WD[6:0]);
            m_tgt = sat;
            m_since = 0;
            if (sat != m_cur) m_ramp = 1;
            else begin m_ramp = 0; m_done = 1; end
          end
          2'd1: m_int = int'(WD[15:0]);
          2'd2: if (WD[0] && m_ramp) begin m_ramp = 0; m_since = 0; end
          default: ;
        endcase
      end
    end
  end

  // Single compare process, away from the active edge
  always @(negedge clk) begin
    chk("duty_wd", 32'(duty_wd), 32'(m_duty));
    chk("duty_we", 32'(duty_we), 32'(m_we));
    chk("busy",    32'(busy),    32'(m_ramp));
    chk("done",    32'(done),    32'(m_done));
    chk("rd",      RD,           exp_rd(A));
    if (duty_we === 1'b1) evq.push_back('{cyc, int'(duty_wd), done});
  end

  task automatic next();
    @(posedge clk); #2;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    WE = 1'b1; A = a; WD = wd;
    next();
    WE = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      next();
      if (done === 1'b1) break;
    end
    if (k == 400) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_duty(input int val, input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      next();
      if (duty_we === 1'b1 && int'(duty_wd) == val) break;
    end
    if (k == 400) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int dn_cnt;
    bit busy_seen;
    int t;
    rst = 1'b0; WE = 1'b0; A = 2'd2; WD = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_duty_wd", 32'(duty_wd), 32'd0);
    chk("rst_duty_we", 32'(duty_we), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_status",  RD,           32'd0);
    next(); next();
    rst = 1'b0;

    // Ramp up 0 -> 3, two base ticks per step
    bus_write(2'd1, 32'd2);
    evq.delete();
    bus_write(2'd0, 32'd3);
    t = wr_cyc;
    wait_done("up");
    chk("up_busy_after", 32'(busy), 32'd0);
    next();
    chk("up_busy_next", 32'(busy), 32'd0);
    chk("up_count", 32'(evq.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < evq.size()) begin
        chk("up_val",  32'(evq[i].val),   32'(i + 1));
        chk("up_time", 32'(evq[i].c - t), 32'(8 * (i + 1)));
        chk("up_done", 32'(evq[i].dn),    32'(i == 2));
      end
    end

    // Saturating jump
    bus_write(2'd1, 32'd0);
    evq.delete();
    bus_write(2'd0, 32'h7F);
    t = wr_cyc;
    wait_done("jump");
    next();
    chk("jump_count", 32'(evq.size()), 32'd1);
    if (evq.size() > 0) begin
      chk("jump_val",  32'(evq[0].val),   32'd100);
      chk("jump_time", 32'(evq[0].c - t), 32'd1);
      chk("jump_done", 32'(evq[0].dn),    32'd1);
    end
    A = 2'd2;
    #1 chk("jump_status", RD, 32'd25600);

    // Ramp down from 10 toward 5, retarget to 9 after two steps
    bus_write(2'd0, 32'd10);
    wait_done("pre_down");
    bus_write(2'd1, 32'd1);
    evq.delete();
    bus_write(2'd0, 32'd5);
    t = wr_cyc;
    wait_duty(8, "down");
    bus_write(2'd0, 32'd9);
    chk("down_count", 32'(evq.size()), 32'd2);
    if (evq.size() >= 2) begin
      chk("down_v0", 32'(evq[0].val), 32'd9);
      chk("down_t0", 32'(evq[0].c - t), 32'd4);
      chk("down_v1", 32'(evq[1].val), 32'd8);
      chk("down_t1", 32'(evq[1].c - t), 32'd8);
    end
    evq.delete();
    t = wr_cyc;
    wait_done("retarget");
    next();
    chk("rt_count", 32'(evq.size()), 32'd1);
    if (evq.size() > 0) begin
      chk("rt_val",  32'(evq[0].val),   32'd9);
      chk("rt_time", 32'(evq[0].c - t), 32'd4);
      chk("rt_done", 32'(evq[0].dn),    32'd1);
    end

    // Abort after first step of 0 -> 5
    bus_write(2'd1, 32'd0);
    bus_write(2'd0, 32'd0);
    wait_done("pre_abort");
    bus_write(2'd1, 32'd1);
    bus_write(2'd0, 32'd5);
    wait_duty(1, "abort");
    bus_write(2'd2, 32'd1);
    evq.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (20) next();
    chk("abort_no_we",  32'(evq.size()), 32'd0);
    chk("abort_status", RD, 32'd256);
    chk("abort_duty",   32'(duty_wd), 32'd1);

    // Asynchronous reset between ticks
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'd50);
    wait_duty(2, "pre_rst");
    next();
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_duty_wd", 32'(duty_wd), 32'd0);
    chk("mid_rst_duty_we", 32'(duty_we), 32'd0);
    chk("mid_rst_busy",    32'(busy),    32'd0);
    chk("mid_rst_status",  RD,           32'd0);
    next(); next();
    rst = 1'b0;

    // Same-value write
    evq.delete();
    bus_write(2'd0, 32'd0);
    dn_cnt = int'(done);
    busy_seen = busy;
    repeat (5) begin
      next();
      dn_cnt += int'(done);
      busy_seen |= busy;
    end
    chk("same_done_cnt", 32'(dn_cnt), 32'd1);
    chk("same_busy",     32'(busy_seen), 32'd0);
    chk("same_no_we",    32'(evq.size()), 32'd0);

    // Random bus traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      WD = $urandom;
      WE = 1'b1;
      if (r < 5) begin
        A = 2'd0;
        if ($urandom_range(0, 3) != 0) begin
          t = m_cur + $urandom_range(0, 12) - 6;
          if (t < 0) t = 0;
          WD[6:0] = 7'(t);
        end
      end else if (r < 7) begin
        A = 2'd1;
        WD[15:0] = 16'($urandom_range(0, 5));
      end else if (r < 8) begin
        A = 2'd2;
      end else if (r < 9) begin
        A = 2'd3;
      end else begin
        WE = 1'b0;
        A = 2'($urandom_range(0, 3));
      end
      next();
    end
    WE = 1'b0;
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
